// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store controller with registered memory handshake,
// lane steering, load extension, fault pulses and busy-timeout abort.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  MEM_READ,
  input  logic [2:0]  MEM_WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] STORE_DATA,
  output logic        BUSY_WAIT,
  output logic [31:0] LOAD_DATA,
  output logic        MISALIGN,
  output logic        ILLEGAL,
  output logic        BUS_ERR,
  output logic [31:0] MEM_ADDR,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [3:0]  MEM_BYTE_EN,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_BUSY
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t         state;
  logic [CW-1:0]  tmo_cnt;
  logic [31:0]    cnt_next;
  logic [2:0]     op_code;
  logic [1:0]     op_lane;

  logic           rd_ok, wr_ok;
  logic           op_illegal, is_load, is_store, op_misalign, op_valid;
  logic [1:0]     sz;
  logic [3:0]     be_next;
  logic [31:0]    wdata_next;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    ld_ext;

  assign rd_ok = (MEM_READ == 3'b001) || (MEM_READ == 3'b010) || (MEM_READ == 3'b011) ||
                 (MEM_READ == 3'b101) || (MEM_READ == 3'b110);
  assign wr_ok = (MEM_WRITE == 3'b001) || (MEM_WRITE == 3'b010) || (MEM_WRITE == 3'b011);

  assign op_illegal = ((|MEM_READ) && !rd_ok) || ((|MEM_WRITE) && !wr_ok) ||
                      ((|MEM_READ) && (|MEM_WRITE));
  assign is_load    = (|MEM_READ) && !op_illegal;
  assign is_store   = (|MEM_WRITE) && !op_illegal;

  // Code bits [1:0] encode the access size for both loads and stores: 01 byte, 10 half, 11 word.
  assign sz          = is_load ? MEM_READ[1:0] : MEM_WRITE[1:0];
  assign op_misalign = (is_load || is_store) &&
                       (((sz == 2'b10) && ADDRESS[0]) || ((sz == 2'b11) && (|ADDRESS[1:0])));
  assign op_valid    = (is_load || is_store) && !op_misalign;

  assign BUSY_WAIT = ((state == IDLE) && op_valid) || (state == ACCESS);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = '0;
    if (is_store) begin
      case (sz)
        2'b01: begin
          be_next    = 4'b0001 << ADDRESS[1:0];
          wdata_next = {4{STORE_DATA[7:0]}};
        end
        2'b10: begin
          be_next    = ADDRESS[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{STORE_DATA[15:0]}};
        end
        default: wdata_next = STORE_DATA;
      endcase
    end
  end

  assign ld_byte = MEM_RDATA[{op_lane, 3'b000} +: 8];
  assign ld_half = op_lane[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];

  always_comb begin
    ld_ext = MEM_RDATA;
    case (op_code)
      3'b001:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {24'b0, ld_byte};
      3'b110:  ld_ext = {16'b0, ld_half};
      default: ld_ext = MEM_RDATA;
    endcase
  end

  assign cnt_next = 32'(tmo_cnt) + 32'd1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      op_code     <= '0;
      op_lane     <= '0;
      LOAD_DATA   <= '0;
      MISALIGN    <= 1'b0;
      ILLEGAL     <= 1'b0;
      BUS_ERR     <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_RD      <= 1'b0;
      MEM_WR      <= 1'b0;
      MEM_BYTE_EN <= '0;
      MEM_WDATA   <= '0;
    end else begin
      MISALIGN <= 1'b0;
      ILLEGAL  <= 1'b0;
      BUS_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            MEM_ADDR    <= {ADDRESS[31:2], 2'b00};
            MEM_RD      <= is_load;
            MEM_WR      <= is_store;
            MEM_BYTE_EN <= be_next;
            MEM_WDATA   <= wdata_next;
            op_code     <= MEM_READ;
            op_lane     <= ADDRESS[1:0];
            tmo_cnt     <= '0;
            state       <= ACCESS;
          end else begin
            ILLEGAL  <= op_illegal;
            MISALIGN <= op_misalign;
          end
        end
        ACCESS: begin
          if (MEM_BUSY) begin
            tmo_cnt <= cnt_next[CW-1:0];
            if ((TIMEOUT_CYCLES != 0) && (cnt_next == 32'(TIMEOUT_CYCLES))) begin
              MEM_RD  <= 1'b0;
              MEM_WR  <= 1'b0;
              BUS_ERR <= 1'b1;
              if (MEM_RD) LOAD_DATA <= '0;
              state   <= DONE;
            end
          end else begin
            // MEM_RD is still held here, so it doubles as the "this is a load" flag.
            MEM_RD <= 1'b0;
            MEM_WR <= 1'b0;
            if (MEM_RD) LOAD_DATA <= ld_ext;
            state  <= DONE;
          end
        end
        DONE: begin
          tmo_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
